seq_detector_prog: RTL

//  Programmable serial bit-sequence detector; successor to the fixed 4-bit Mealy detector.
//  - Pattern, length (1..MAX_LEN) and overlap mode are runtime-configurable.
//  - Output timing is Mealy (combinational) or registered, chosen at build time.
//  - Match events are counted in a saturating counter.
//  - Sits on a 1-bit serial data path gated by in_valid; feeds status and interrupt logic.

---
 rtl/seq_det_pkg.sv | 21 ++
 rtl/seq_detector_prog_if.sv | 31 +++
 rtl/sat_counter.sv | 45 ++++
 rtl/seq_detector_prog.sv | 123 ++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable sequence detector.
package seq_det_pkg;

    // Output timing selection for the match output
    localparam int OUT_MEALY = 0;
    localparam int OUT_REG   = 1;

    // Smallest pattern length the history datapath supports
    localparam int MAX_LEN_MIN = 2;

    // Width needed to hold a length value of 0..max_len
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Sanity range check of the MAX_LEN build parameter
    function automatic bit max_len_ok(input int max_len);
        return (max_len >= MAX_LEN_MIN);
    endfunction

endpackage

// File: rtl/seq_detector_prog_if.sv
// Configuration, serial data and status bundle of the sequence detector.
interface seq_detector_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    import seq_det_pkg::*;

    localparam int LEN_W = len_w(MAX_LEN);

    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               x;
    logic               cnt_clr;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               cnt_sat;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, x, cnt_clr,
        input  match, match_count, cnt_sat
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, x, cnt_clr,
        output match, match_count, cnt_sat
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with sticky saturation flag; clear beats increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         sat_o
);

    logic [W-1:0] count_q, count_d;
    logic         sat_q, sat_d;

    // Next count: clear first, otherwise step unless already at all-ones
    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr_i) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else begin
            if (inc_i && !(&count_q)) begin
                count_d = count_q + W'(1);
            end
            sat_d = sat_q | (&count_d);
        end
    end

    // Counter and flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count_o = count_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial bit-sequence detector with match counter.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int REG_OUT = OUT_MEALY
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_detector_prog_if.slave bus
);

    localparam int                LEN_W    = len_w(MAX_LEN);
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]  FILL_MAX = LEN_W'(MAX_LEN - 1);

    generate
        if (!max_len_ok(MAX_LEN)) begin : g_bad_max_len
            $error("seq_detector_prog: MAX_LEN must be at least 2");
        end
    endgenerate

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic               len_nz;
    logic               fill_ok;
    logic               eq;
    logic               hit;

    // Masked compare of history plus current bit against the active pattern
    always_comb begin
        window = {hist_q, bus.x};
        mask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len_q)) mask[i] = 1'b1;
        end
        len_nz  = (len_q != '0);
        fill_ok = len_nz && (fill_q >= (len_q - LEN_W'(1)));
        eq      = (((window ^ pattern_q) & mask) == '0);
        hit     = bus.in_valid & ~bus.cfg_load & len_nz & fill_ok & eq;
    end

    // Config latch and history/fill update; a load flushes and drops the offered bit
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        if (bus.cfg_load) begin
            pattern_d = bus.cfg_pattern;
            len_d     = (bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;
            overlap_d = bus.cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
        end else if (bus.in_valid && len_nz) begin
            if (hit && !overlap_q) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[MAX_LEN-2:0];
                fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + LEN_W'(1);
            end
        end
    end

    // Config and history registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
        end
    end

    generate
        if (REG_OUT == OUT_REG) begin : g_reg_out
            logic match_q, match_d;

            // Registered match, cleared by a config load
            always_comb begin
                match_d = bus.cfg_load ? 1'b0 : hit;
            end

            // Match output register
            always_ff @(posedge clk) begin
                if (!rst_n) match_q <= 1'b0;
                else        match_q <= match_d;
            end

            assign bus.match = match_q;
        end else begin : g_mealy_out
            assign bus.match = hit;
        end
    endgenerate

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (bus.cnt_clr),
        .inc_i   (hit),
        .count_o (bus.match_count),
        .sat_o   (bus.cnt_sat)
    );

endmodule
